// File: rtl/fb_arb_pkg.sv
// Shared types and default display geometry for the framebuffer port arbiter.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fb_arb_state_t;

    localparam int FB_WORDS_PER_LINE = 80;
    localparam int FB_FETCH_SX       = 640;
    localparam int FB_V_ACTIVE       = 480;
    localparam int FB_SCREEN         = 524;

endpackage

// File: rtl/fb_fetch_seq.sv
// Scanline prefetch sequencer: word counter, running read address and the
// one-cycle read-valid pipeline that drives the line-buffer write.
module fb_fetch_seq
    import fb_arb_pkg::*;
#(
    parameter int WORDS_PER_LINE = FB_WORDS_PER_LINE,
    parameter int ADDR_W         = 16,
    parameter int LB_W           = $clog2(FB_WORDS_PER_LINE)
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic              start_i,
    input  logic              fetch_i,
    input  logic [9:0]        next_line_i,
    output logic              last_o,
    output logic [ADDR_W-1:0] rd_addr_nxt_o,
    output logic              lb_we_o,
    output logic [LB_W-1:0]   lb_addr_o
);

    localparam logic [LB_W-1:0] LAST_WORD = LB_W'(WORDS_PER_LINE - 1);

    logic [LB_W-1:0]   word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] base_s;
    logic              lb_we_q;
    logic [LB_W-1:0]   lb_addr_q;

    // Constant-coefficient product, evaluated only once per line at the trigger.
    assign base_s        = ADDR_W'(32'(next_line_i) * 32'(WORDS_PER_LINE));
    assign last_o        = (word_q == LAST_WORD);
    assign rd_addr_nxt_o = start_i ? base_s : (addr_q + ADDR_W'(1));
    assign lb_we_o       = lb_we_q;
    assign lb_addr_o     = lb_addr_q;

    // Next word index and running address.
    always_comb begin
        word_d = word_q;
        addr_d = addr_q;
        if (start_i) begin
            word_d = {LB_W{1'b0}};
            addr_d = base_s;
        end else if (fetch_i && !last_o) begin
            word_d = word_q + LB_W'(1);
            addr_d = addr_q + ADDR_W'(1);
        end else begin
            word_d = word_q;
            addr_d = addr_q;
        end
    end

    // Counter registers and read-valid pipeline (data returns one cycle after the address).
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            word_q    <= {LB_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            lb_we_q   <= 1'b0;
            lb_addr_q <= {LB_W{1'b0}};
        end else begin
            word_q    <= word_d;
            addr_q    <= addr_d;
            lb_we_q   <= fetch_i;
            lb_addr_q <= fetch_i ? word_q : {LB_W{1'b0}};
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: hblank scanline prefetch has priority over draw writes.
// Optional macro FB_ARB_STALL_STATS_EN adds a saturating write-stall counter output.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int WORDS_PER_LINE = FB_WORDS_PER_LINE,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int FETCH_SX       = FB_FETCH_SX,
    parameter int V_ACTIVE       = FB_V_ACTIVE,
    parameter int SCREEN         = FB_SCREEN
) (
    input  logic                              clk_pix,
    input  logic                              rst,
    input  logic [9:0]                        sx,
    input  logic [9:0]                        sy,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic                              mem_we,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic                              lb_we,
    output logic [$clog2(WORDS_PER_LINE)-1:0] lb_addr,
    output logic [DATA_W-1:0]                 lb_wdata,
`ifdef FB_ARB_STALL_STATS_EN
    output logic [31:0]                       stall_count,
`endif
    output logic                              fetch_busy
);

    localparam int LB_W = $clog2(WORDS_PER_LINE);

    if (FETCH_SX + WORDS_PER_LINE + 2 > 800) begin : g_geom_check
        $error("fb_port_arbiter: line fetch does not fit inside horizontal blanking");
    end

    fb_arb_state_t     state_q, state_d;
    logic              fetch_trig_s;
    logic [9:0]        next_line_s;
    logic              start_s;
    logic              fetching_s;
    logic              wr_acc_s;
    logic              seq_last_s;
    logic [ADDR_W-1:0] seq_rd_addr_s;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    assign fetch_trig_s = (sx == 10'(FETCH_SX)) &&
                          ((sy < 10'(V_ACTIVE - 1)) || (sy == 10'(SCREEN)));
    assign next_line_s  = (sy == 10'(SCREEN)) ? 10'd0 : (sy + 10'd1);
    assign start_s      = (state_q == IDLE) && fetch_trig_s;
    assign fetching_s   = (state_q == FETCH);
    assign wr_ready     = (state_q == IDLE) && !fetch_trig_s && !rst;
    assign wr_acc_s     = wr_valid && wr_ready;

    fb_fetch_seq #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .ADDR_W         (ADDR_W),
        .LB_W           (LB_W)
    ) u_seq (
        .clk_pix        (clk_pix),
        .rst            (rst),
        .start_i        (start_s),
        .fetch_i        (fetching_s),
        .next_line_i    (next_line_s),
        .last_o         (seq_last_s),
        .rd_addr_nxt_o  (seq_rd_addr_s),
        .lb_we_o        (lb_we),
        .lb_addr_o      (lb_addr)
    );

    // Fetch FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fetch_trig_s ? FETCH : IDLE;
            FETCH:   state_d = seq_last_s ? DRAIN : FETCH;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port mux: read addresses for the fetch, otherwise an accepted draw write.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (start_s || (fetching_s && !seq_last_s)) begin
            mem_addr_d = seq_rd_addr_s;
        end else if (wr_acc_s) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
        end else begin
            mem_we_d = 1'b0;
        end
    end

    // State and registered RAM port.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_we_q    <= 1'b0;
            mem_wdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign fetch_busy = (state_q != IDLE);
    assign lb_wdata   = lb_we ? mem_rdata : {DATA_W{1'b0}};

`ifdef FB_ARB_STALL_STATS_EN
    logic [31:0] stall_q;

    // Saturating count of cycles a draw write waited on the port.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else if (wr_valid && !wr_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end else begin
            stall_q <= stall_q;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: stimulus pushes expected line-buffer and
// RAM-write events; a negedge monitor pops and compares them as the DUT emits them.
module tb_fb_port_arbiter;

    logic        clk_pix = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sx = 10'd0;
    logic [9:0]  sy = 10'd0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_addr = 16'd0;
    logic [31:0] wr_data = 32'd0;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        lb_we;
    logic [6:0]  lb_addr;
    logic [31:0] lb_wdata;
    logic        fetch_busy;
`ifdef FB_ARB_STALL_STATS_EN
    logic [31:0] stall_count;
`endif

    fb_port_arbiter dut (
        .clk_pix     (clk_pix),
        .rst         (rst),
        .sx          (sx),
        .sy          (sy),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .lb_we       (lb_we),
        .lb_addr     (lb_addr),
        .lb_wdata    (lb_wdata),
`ifdef FB_ARB_STALL_STATS_EN
        .stall_count (stall_count),
`endif
        .fetch_busy  (fetch_busy)
    );

    typedef struct {
        int          c;
        logic [15:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t lbq[$];
    exp_t wrq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk_pix = ~clk_pix;

    always @(posedge clk_pix) cyc <= cyc + 1;

    function automatic logic [31:0] ram_f(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    // RAM model: one-cycle read latency, contents are a fixed function of the address.
    always @(posedge clk_pix) mem_rdata <= ram_f(mem_addr);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk_pix);
            #1;
        end
    endtask

    task automatic push_line(input int t, input int line, input int nwords);
        exp_t e;
        for (int k = 0; k < nwords; k++) begin
            e.c = t + 2 + k;
            e.a = 16'(k);
            e.d = ram_f(16'(line * 80 + k));
            lbq.push_back(e);
        end
    endtask

    // Monitor: every lb_we / mem_we beat must match the next expected event.
    always @(negedge clk_pix) begin
        if (lb_we) begin
            if (lbq.size() == 0) begin
                chk("lb_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = lbq.pop_front();
                chk("lb_cycle", 64'(cyc), 64'(mon_e.c));
                chk("lb_addr", 64'(lb_addr), 64'(mon_e.a));
                chk("lb_wdata", 64'(lb_wdata), 64'(mon_e.d));
            end
        end
        if (mem_we) begin
            if (wrq.size() == 0) begin
                chk("wr_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = wrq.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(mon_e.c));
                chk("wr_addr", 64'(mem_addr), 64'(mon_e.a));
                chk("wr_data", 64'(mem_wdata), 64'(mon_e.d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        int   s;
        exp_t e;

        // Reset state
        goto(3);
        #2;
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_lb_we", 64'(lb_we), 64'd0);
        chk("rst_lb_addr", 64'(lb_addr), 64'd0);
        chk("rst_lb_wdata", 64'(lb_wdata), 64'd0);
        chk("rst_busy", 64'(fetch_busy), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        rst = 1'b0;

        // Fetch of line 1 from sy=0
        goto(5);
        t = cyc;
        push_line(t, 1, 80);
        sx = 10'd640;
        sy = 10'd0;
        #2;
        chk("f1_busy_T", 64'(fetch_busy), 64'd0);
        chk("f1_ready_T", 64'(wr_ready), 64'd0);
        goto(t + 1);
        sx = 10'd641;
        #2;
        chk("f1_busy_T1", 64'(fetch_busy), 64'd1);
        chk("f1_addr_first", 64'(mem_addr), 64'd80);
        chk("f1_we_rd", 64'(mem_we), 64'd0);
        goto(t + 80);
        #2;
        chk("f1_addr_last", 64'(mem_addr), 64'd159);
        goto(t + 81);
        #2;
        chk("f1_busy_T81", 64'(fetch_busy), 64'd1);
        chk("f1_ready_T81", 64'(wr_ready), 64'd0);
        goto(t + 82);
        #2;
        chk("f1_busy_T82", 64'(fetch_busy), 64'd0);
        chk("f1_ready_T82", 64'(wr_ready), 64'd1);

        // Last line of the frame fetches line 0
        goto(t + 85);
        t = cyc;
        push_line(t, 0, 80);
        sx = 10'd640;
        sy = 10'd524;
        goto(t + 1);
        sx = 10'd641;
        #2;
        chk("f0_addr_first", 64'(mem_addr), 64'd0);
        goto(t + 85);

        // Last active line and vertical blanking: no fetch
        sx = 10'd640;
        sy = 10'd479;
        #2;
        chk("nf479_ready", 64'(wr_ready), 64'd1);
        goto(cyc + 1);
        sx = 10'd641;
        #2;
        chk("nf479_busy", 64'(fetch_busy), 64'd0);
        goto(cyc + 1);
        sx = 10'd640;
        sy = 10'd500;
        goto(cyc + 1);
        sx = 10'd641;
        #2;
        chk("nf500_busy", 64'(fetch_busy), 64'd0);
        goto(cyc + 3);
        #2;
        chk("nf500_busy_late", 64'(fetch_busy), 64'd0);

        // Write requested in the trigger cycle stalls until the fetch drains
        goto(cyc + 1);
        t = cyc;
        push_line(t, 11, 80);
        sx = 10'd640;
        sy = 10'd10;
        wr_valid = 1'b1;
        wr_addr = 16'h1234;
        wr_data = 32'hDEAD_BEEF;
        e.c = t + 83;
        e.a = 16'h1234;
        e.d = 32'hDEAD_BEEF;
        wrq.push_back(e);
        #2;
        chk("st_ready_T", 64'(wr_ready), 64'd0);
        goto(t + 1);
        sx = 10'd641;
        goto(t + 81);
        #2;
        chk("st_ready_T81", 64'(wr_ready), 64'd0);
        goto(t + 82);
        #2;
        chk("st_ready_T82", 64'(wr_ready), 64'd1);
        goto(t + 83);
        wr_valid = 1'b0;
`ifdef FB_ARB_STALL_STATS_EN
        chk("stall_count", 64'(stall_count), 64'd82);
`endif

        // Five back-to-back writes in IDLE
        goto(t + 86);
        s = cyc;
        for (int i = 0; i < 5; i++) begin
            goto(s + i);
            wr_valid = 1'b1;
            wr_addr = 16'h0100 + 16'(i);
            wr_data = 32'hC0DE_0000 + 32'(i);
            e.c = s + 1 + i;
            e.a = wr_addr;
            e.d = wr_data;
            wrq.push_back(e);
        end
        goto(s + 5);
        wr_valid = 1'b0;
        goto(s + 8);

        // Reset during the 10th read aborts the fetch
        t = cyc;
        push_line(t, 51, 9);
        sx = 10'd640;
        sy = 10'd50;
        goto(t + 1);
        sx = 10'd641;
        goto(t + 10);
        #2;
        chk("ra_addr_10th", 64'(mem_addr), 64'd4089);
        rst = 1'b1;
        #1;
        chk("ra_ready_in_rst", 64'(wr_ready), 64'd0);
        goto(t + 11);
        rst = 1'b0;
        #2;
        chk("ra_mem_addr", 64'(mem_addr), 64'd0);
        chk("ra_mem_we", 64'(mem_we), 64'd0);
        chk("ra_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("ra_lb_we", 64'(lb_we), 64'd0);
        chk("ra_lb_addr", 64'(lb_addr), 64'd0);
        chk("ra_lb_wdata", 64'(lb_wdata), 64'd0);
        chk("ra_busy", 64'(fetch_busy), 64'd0);
        chk("ra_ready_after", 64'(wr_ready), 64'd1);
`ifdef FB_ARB_STALL_STATS_EN
        chk("ra_stall_clear", 64'(stall_count), 64'd0);
`endif
        goto(t + 15);
        #2;
        chk("ra_busy_late", 64'(fetch_busy), 64'd0);

        // Next trigger after the abort fetches normally
        t = cyc;
        push_line(t, 101, 80);
        sx = 10'd640;
        sy = 10'd100;
        goto(t + 1);
        sx = 10'd641;
        #2;
        chk("rf_addr_first", 64'(mem_addr), 64'd8080);
        goto(t + 90);
        #2;
        chk("rf_busy_done", 64'(fetch_busy), 64'd0);

        chk("lbq_drained", 64'(lbq.size()), 64'd0);
        chk("wrq_drained", 64'(wrq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port framebuffer RAM between two users: the display scanline prefetch and a drawing-engine write port.
- During horizontal blanking the prefetch copies the next line's words from RAM into the line buffer; drawing writes fill all other cycles.
- Sits between the display timing generator (sx/sy) and the framebuffer/line-buffer RAMs; runs on clk_pix.

Parameters:
- WORDS_PER_LINE, 80, framebuffer words per display line.
- ADDR_W, 16, framebuffer word-address width.
- DATA_W, 32, framebuffer word width.
- FETCH_SX, 640, sx value that triggers a fetch (first hblank pixel).
- V_ACTIVE, 480, active lines.
- SCREEN, 524, last line index of the frame.
- Elaboration constraint: FETCH_SX + WORDS_PER_LINE + 2 <= 800.

Ports:
- clk_pix  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- sx  in  10  horizontal position from timing generator
- sy  in  10  vertical position from timing generator
- wr_valid  in  1  draw write request
- wr_ready  out  1  draw write accepted this cycle
- wr_addr  in  ADDR_W  draw write word address
- wr_data  in  DATA_W  draw write data
- mem_addr  out  ADDR_W  framebuffer address (registered)
- mem_we  out  1  framebuffer write enable (registered)
- mem_wdata  out  DATA_W  framebuffer write data (registered)
- mem_rdata  in  DATA_W  framebuffer read data, valid 1 cycle after mem_addr
- lb_we  out  1  line-buffer write enable
- lb_addr  out  clog2(WORDS_PER_LINE)  line-buffer word index
- lb_wdata  out  DATA_W  line-buffer data (= mem_rdata)
- fetch_busy  out  1  high while state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, pipeline valid cleared. Reset mid-fetch aborts the fetch; no lb_we after the reset cycle. The partial line is not refetched.
- fetch_trig (combinational) = (sx == FETCH_SX) && (sy < V_ACTIVE-1 || sy == SCREEN).
- next_line = (sy == SCREEN) ? 0 : sy+1. This value is latched at the trigger.
- FSM states:
  - IDLE -> FETCH on fetch_trig.
  - FETCH issues one read per cycle, word index 0..WORDS_PER_LINE-1. After the last word -> DRAIN.
  - DRAIN lasts 1 cycle (last read data returns) -> IDLE.
- Read address = next_line*WORDS_PER_LINE + word. Width-truncated to ADDR_W. Implement with a running base register; no multiplier required.
- Timing, with trigger at cycle T:
  - mem_addr = word k at T+1+k, with mem_we=0.
  - lb_we=1 with lb_addr=k and lb_wdata=mem_rdata at T+2+k.
  - fetch_busy high T+1 through T+WORDS_PER_LINE+1.
- Write port: wr_ready = (state==IDLE) && !fetch_trig && !rst. It is combinational and independent of wr_valid.
- Accept when wr_valid && wr_ready. At the next cycle: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
- When no write is accepted and no fetch is running, mem_we=0. mem_addr/mem_wdata hold their previous values.
- Requester holds wr_* stable while wr_valid && !wr_ready.
- Simultaneous fetch_trig and wr_valid: fetch wins, wr_ready=0, write stalls until DRAIN completes.
- Fetch always has priority. No fetch underrun is possible given the elaboration constraint.
- sy in the range V_ACTIVE-1..SCREEN-1: no trigger; writes have the port for the whole line.
- sx/sy jumps (timing reset): the FSM is unaffected apart from trigger evaluation.

Optional Feature:
- Macro FB_ARB_STALL_STATS_EN.
- Defined: adds output stall_count [31:0]. It increments (saturating at 0xFFFFFFFF) each cycle with wr_valid && !wr_ready, and clears on rst.
- Undefined: port absent, no counter logic.

Decomposition:
- Package fb_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fb_arb_state_t;
  - localparams for the default geometry (80, 640, 480, 524).
- One natural sub-module: fb_fetch_seq (word counter, running base address, 1-cycle read-valid pipeline). The arbitration muxing stays in the top.

Test Plan:
- After rst, sy=0, sx=640 -> fetch of line 1: mem_addr 80..159 on cycles T+1..T+80; lb_we at T+2..T+81 with lb_addr 0..79; fetch_busy low at T+82.
- sy=524, sx=640 -> line 0 fetch, mem_addr 0..79; sy=479 or 500 at sx=640 -> no fetch, fetch_busy stays 0.
- wr_valid held with wr_addr=0x1234, wr_data=0xDEADBEEF, asserted in the trigger cycle -> wr_ready=0 for 82 cycles; then accepted; mem_we=1 with that addr/data one cycle later, exactly once.
- Back-to-back writes in IDLE, 5 beats -> 5 consecutive mem_we cycles, addresses in order; none lost or duplicated.
- rst asserted at the 10th read of a fetch -> next cycle state IDLE, all outputs 0, no further lb_we; the next trigger fetches normally.
- With FB_ARB_STALL_STATS_EN: write pending across a full fetch -> stall_count = 82.
